mux_rr_arbiter: RTL and testbench

Two-requester arbiter that shares a single 3-bit output channel between sources A and B by sequencing the select of a 2:1 mux. Each grant covers a burst of one or more beats. A registered output stage with valid/ready handshake drives the downstream consumer. Between grants, a round-robin pointer decides who goes next.

---
 rtl/mux_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
`timescale 1ns/1ps
// Two-source burst arbiter driving one registered valid/ready output channel.
// Define MUX_ARB_FIXED_PRIO_EN to make A win every tie instead of round-robin.
module mux_rr_arbiter #(
  parameter int WIDTH     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             ack_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_last,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

`ifdef MUX_ARB_FIXED_PRIO_EN
  localparam logic RR_EN = 1'b0;
`else
  localparam logic RR_EN = 1'b1;
`endif
  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  // Handshake: a beat moves from source x when ack_x is high at a rising edge;
  // the output beat moves downstream when out_valid & out_ready at a rising edge.

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic             out_last_q;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  // A release hands the next tie to the other source (prio stays 0 when fixed).
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_a && (!req_b || !prio_q)) state_d = GNT_A;
        else if (req_b)                    state_d = GNT_B;
      end
      GNT_A: begin
        if (ack_a) cnt_d = cnt_q + 4'd1;
        if (!req_a || (ack_a && (last_a || cnt_q == CNT_LAST))) begin
          state_d = IDLE;
          prio_d  = RR_EN;
          cnt_d   = '0;
        end
      end
      GNT_B: begin
        if (ack_b) cnt_d = cnt_q + 4'd1;
        if (!req_b || (ack_b && (last_b || cnt_q == CNT_LAST))) begin
          state_d = IDLE;
          prio_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    can_load  = !out_valid_q || out_ready;
    ack_a     = !rst && (state_q == GNT_A) && req_a && can_load;
    ack_b     = !rst && (state_q == GNT_B) && req_b && can_load;
    load      = ack_a || ack_b;
    load_data = ack_b ? data_b : data_a;
    load_last = ack_b ? last_b : last_a;
    gnt_a     = (state_q == GNT_A);
    gnt_b     = (state_q == GNT_B);
    dbg_state = state_q;
  end

  // Payload fields only change on a load, so they hold while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= load_data;
      out_src_q   <= ack_b;
      out_last_q  <= load_last;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_mux_rr_arbiter;

  localparam int WIDTH     = 3;
  localparam int MAX_BURST = 4;
`ifdef MUX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             req_a, last_a, ack_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b, last_b, ack_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a, gnt_b;
  logic             out_valid, out_ready, out_src, out_last;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  logic [WIDTH:0]   src_a_q[$];
  logic [WIDTH:0]   src_b_q[$];
  logic [WIDTH+1:0] obs_q[$];
  bit               pause_en;
  int               ready_pct;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .last_a(last_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b), .ack_b(ack_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    req_a = 1'b0; data_a = '0; last_a = 1'b0;
    req_b = 1'b0; data_b = '0; last_b = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Sources present the head of their beat queue; a beat is consumed on ack.
  task automatic run_cycle();
    logic [WIDTH:0] ha, hb;
    ha = (src_a_q.size() > 0) ? src_a_q[0] : '0;
    hb = (src_b_q.size() > 0) ? src_b_q[0] : '0;
    req_a  = (src_a_q.size() > 0) && !(pause_en && $urandom_range(0, 7) == 0);
    req_b  = (src_b_q.size() > 0) && !(pause_en && $urandom_range(0, 7) == 0);
    data_a = ha[WIDTH-1:0]; last_a = ha[WIDTH];
    data_b = hb[WIDTH-1:0]; last_b = hb[WIDTH];
    out_ready = ($urandom_range(0, 99) < ready_pct);
    settle();
    if (out_valid && out_ready) obs_q.push_back({out_src, out_last, out_data});
    if (ack_a && src_a_q.size() > 0) void'(src_a_q.pop_front());
    if (ack_b && src_b_q.size() > 0) void'(src_b_q.pop_front());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1; data_a = 3'b111; last_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt_a, gnt_b, ack_a, ack_b, out_valid, out_src, out_last} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {gnt_a, gnt_b, ack_a, ack_b, out_valid, out_src, out_last});
    end
    checks++;
    if ({dbg_state, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_state_data: got state=%0d data=%0h expected 0/0", dbg_state, out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_a = 1'b1; data_a = 3'b101; last_a = 1'b1; out_ready = 1'b1;
    settle();
    checks++;
    if ({gnt_a, ack_a} !== 2'b00) begin
      errors++; $display("FAIL single_c0: got gnt/ack=%b expected 00", {gnt_a, ack_a});
    end
    next_cycle(); settle();
    checks++;
    if ({gnt_a, ack_a, out_valid} !== 3'b110) begin
      errors++; $display("FAIL single_c1: got gnt/ack/valid=%b expected 110", {gnt_a, ack_a, out_valid});
    end
    next_cycle();
    req_a = 1'b0;
    settle();
    checks++;
    if ({out_valid, out_data, out_src, out_last} !== {1'b1, 3'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL single_c2_out: got v=%b d=%0h s=%b l=%b expected v=1 d=5 s=0 l=1",
                         out_valid, out_data, out_src, out_last);
    end
    checks++;
    if ({dbg_state, gnt_a} !== 3'b000) begin
      errors++; $display("FAIL single_c2_idle: got state=%0d gnt_a=%b expected 0/0", dbg_state, gnt_a);
    end
    next_cycle(); settle();
    checks++;
    if ({out_valid, out_data} !== {1'b0, 3'd5}) begin
      errors++; $display("FAIL single_drain: got v=%b d=%0h expected v=0 d=5", out_valid, out_data);
    end
  endtask

  task automatic test_tie_rr();
    logic [WIDTH-1:0] da, db;
    logic [1:0]       exp_g;
    int               w;
    do_reset();
    da = WIDTH'($urandom); db = WIDTH'($urandom);
    req_a = 1'b1; req_b = 1'b1; data_a = da; data_b = db;
    last_a = 1'b1; last_b = 1'b1; out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) req_a = 1'b0;
      settle();
      if (k % 2 == 1) begin
        w = FIXED ? 0 : ((k - 1) / 2) % 2;
        exp_g = (w != 0) ? 2'b01 : 2'b10;
        checks++;
        if ({gnt_a, gnt_b, ack_a, ack_b} !== {exp_g, exp_g}) begin
          errors++; $display("FAIL tie_grant_c%0d: got gnt/ack=%b expected %b",
                             k, {gnt_a, gnt_b, ack_a, ack_b}, {exp_g, exp_g});
        end
      end else if (k > 0) begin
        w = FIXED ? 0 : ((k - 2) / 2) % 2;
        checks++;
        if ({gnt_a, gnt_b, out_valid, out_src, out_data} !==
            {2'b00, 1'b1, w[0], ((w != 0) ? db : da)}) begin
          errors++; $display("FAIL tie_gap_c%0d: got g=%b%b v=%b s=%b d=%0h expected g=00 v=1 s=%0d d=%0h",
                             k, gnt_a, gnt_b, out_valid, out_src, out_data, w, (w != 0) ? db : da);
        end
      end
      next_cycle();
    end
    settle();
    checks++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      errors++; $display("FAIL tie_b_after_a_drops: got gnt=%b expected 01", {gnt_a, gnt_b});
    end
    req_b = 1'b0;
  endtask

  task automatic test_forced_release();
    logic [WIDTH+1:0] exp_l[$];
    do_reset();
    pause_en = 1'b0; ready_pct = 100;
    src_a_q.delete(); src_b_q.delete(); obs_q.delete();
    for (int i = 1; i <= MAX_BURST + 1; i++) src_a_q.push_back({1'b0, WIDTH'(i)});
    src_b_q.push_back({1'b1, 3'd7});
    for (int i = 1; i <= MAX_BURST; i++) exp_l.push_back({1'b0, 1'b0, WIDTH'(i)});
    exp_l.push_back({1'b1, 1'b1, 3'd7});
    exp_l.push_back({1'b0, 1'b0, WIDTH'(MAX_BURST + 1)});
    repeat (16) begin
      run_cycle();
      next_cycle();
    end
    checks++;
    if (obs_q.size() != exp_l.size()) begin
      errors++; $display("FAIL forced_count: got %0d beats expected %0d", obs_q.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_l[i]) begin
        errors++; $display("FAIL forced_beat%0d: got {src,last,data}=%b expected %b", i, obs_q[i], exp_l[i]);
      end
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a = 1'b1; data_a = 3'b011; last_a = 1'b0; out_ready = 1'b1;
    next_cycle(); settle();
    checks++;
    if ({gnt_a, ack_a} !== 2'b11) begin
      errors++; $display("FAIL bp_first_ack: got gnt/ack=%b expected 11", {gnt_a, ack_a});
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      data_a = 3'b110; out_ready = 1'b0;
      settle();
      checks++;
      if ({out_valid, ack_a, gnt_a, out_data} !== {3'b101, 3'd3}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b ack=%b gnt=%b d=%0h expected v=1 ack=0 gnt=1 d=3",
                           k, out_valid, ack_a, gnt_a, out_data);
      end
    end
    next_cycle();
    out_ready = 1'b1;
    settle();
    checks++;
    if ({ack_a, out_data} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL bp_release_ack: got ack=%b d=%0h expected ack=1 d=3", ack_a, out_data);
    end
    next_cycle();
    data_a = 3'b010; last_a = 1'b1;
    settle();
    checks++;
    if ({ack_a, out_valid, out_data} !== {2'b11, 3'd6}) begin
      errors++; $display("FAIL bp_no_bubble: got ack=%b v=%b d=%0h expected ack=1 v=1 d=6", ack_a, out_valid, out_data);
    end
    next_cycle();
    req_a = 1'b0;
    settle();
    checks++;
    if ({out_valid, out_last, out_data, gnt_a} !== {2'b11, 3'd2, 1'b0}) begin
      errors++; $display("FAIL bp_last: got v=%b l=%b d=%0h gnt=%b expected v=1 l=1 d=2 gnt=0",
                         out_valid, out_last, out_data, gnt_a);
    end
    drive_idle();
  endtask

  task automatic test_withdraw_reset();
    do_reset();
    req_b = 1'b1; data_b = 3'd4; last_b = 1'b0; out_ready = 1'b1;
    next_cycle(); settle();
    checks++;
    if ({gnt_b, ack_b} !== 2'b11) begin
      errors++; $display("FAIL wd_grant_b: got gnt/ack=%b expected 11", {gnt_b, ack_b});
    end
    next_cycle();
    data_b = 3'd5; out_ready = 1'b0;
    next_cycle();
    req_b = 1'b0;
    settle();
    checks++;
    if ({gnt_b, ack_b, out_valid} !== 3'b101) begin
      errors++; $display("FAIL wd_withdraw: got gnt/ack/v=%b expected 101", {gnt_b, ack_b, out_valid});
    end
    next_cycle(); settle();
    checks++;
    if ({dbg_state, gnt_b, out_valid, out_data} !== {2'd0, 1'b0, 1'b1, 3'd4}) begin
      errors++; $display("FAIL wd_idle_held: got state=%0d gnt=%b v=%b d=%0h expected 0/0/1/4",
                         dbg_state, gnt_b, out_valid, out_data);
    end
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    req_a = 1'b1; data_a = 3'd6; last_a = 1'b0;
    settle();
    checks++;
    if ({out_valid, out_data} !== {1'b0, 3'd4}) begin
      errors++; $display("FAIL wd_drained: got v=%b d=%0h expected v=0 d=4", out_valid, out_data);
    end
    next_cycle(); next_cycle(); settle();
    checks++;
    if ({gnt_a, out_valid, out_data} !== {2'b11, 3'd6}) begin
      errors++; $display("FAIL rst_pre: got gnt=%b v=%b d=%0h expected 1/1/6", gnt_a, out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, gnt_a, gnt_b, ack_a, out_data} !== '0) begin
      errors++; $display("FAIL rst_async: got v=%b ga=%b gb=%b ack=%b d=%0h expected all 0",
                         out_valid, gnt_a, gnt_b, ack_a, out_data);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [WIDTH:0]   exp_a_q[$];
    logic [WIDTH:0]   exp_b_q[$];
    logic [WIDTH+1:0] o;
    logic [WIDTH:0]   e;
    logic [1:0]       exp_gnt, exp_ack;
    bit               pend_arb, pend_rel, last_owner;
    int               burst, cyc, len;
    do_reset();
    pause_en = 1'b1; ready_pct = 70;
    src_a_q.delete(); src_b_q.delete(); obs_q.delete();
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 30; b++) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          e[WIDTH-1:0] = WIDTH'($urandom);
          e[WIDTH]     = (i == len - 1);
          if (s == 0) src_a_q.push_back(e);
          else        src_b_q.push_back(e);
        end
      end
    end
    pend_arb = 1'b0; pend_rel = 1'b0; last_owner = 1'b1; burst = 0; cyc = 0;
    exp_gnt = 2'b00;
    while (cyc < 4000 && (src_a_q.size() + src_b_q.size() + exp_a_q.size() + exp_b_q.size() > 0)) begin
      run_cycle();
      if (pend_arb) begin
        checks++;
        if ({gnt_a, gnt_b} !== exp_gnt) begin
          errors++; $display("FAIL rnd_arb cyc%0d: got gnt=%b expected %b", cyc, {gnt_a, gnt_b}, exp_gnt);
        end
      end
      if (pend_rel) begin
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
          errors++; $display("FAIL rnd_release cyc%0d: got gnt=%b expected 00", cyc, {gnt_a, gnt_b});
        end
      end
      if (gnt_a) last_owner = 1'b0;
      if (gnt_b) last_owner = 1'b1;
      exp_ack = {gnt_a && req_a && (!out_valid || out_ready), gnt_b && req_b && (!out_valid || out_ready)};
      checks++;
      if ({ack_a, ack_b} !== exp_ack) begin
        errors++; $display("FAIL rnd_ack cyc%0d: got ack=%b expected %b", cyc, {ack_a, ack_b}, exp_ack);
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if (o[WIDTH+1] == 1'b0 && exp_a_q.size() > 0)      e = exp_a_q.pop_front();
        else if (o[WIDTH+1] == 1'b1 && exp_b_q.size() > 0) e = exp_b_q.pop_front();
        else e = 'x;
        if (o[WIDTH:0] !== e) begin
          errors++; $display("FAIL rnd_beat cyc%0d src%0d: got {last,data}=%b expected %b", cyc, o[WIDTH+1], o[WIDTH:0], e);
        end
      end
      if (!gnt_a && !gnt_b) burst = 0;
      if (ack_a || ack_b) begin
        burst++;
        checks++;
        if (burst > MAX_BURST) begin
          errors++; $display("FAIL rnd_burst_len cyc%0d: got %0d beats limit %0d", cyc, burst, MAX_BURST);
        end
      end
      pend_rel = (gnt_a && (!req_a || (ack_a && (last_a || burst == MAX_BURST)))) ||
                 (gnt_b && (!req_b || (ack_b && (last_b || burst == MAX_BURST))));
      pend_arb = !gnt_a && !gnt_b;
      exp_gnt  = (req_a && req_b) ? ((FIXED || last_owner) ? 2'b10 : 2'b01) :
                 req_a ? 2'b10 : req_b ? 2'b01 : 2'b00;
      if (ack_a) exp_a_q.push_back({last_a, data_a});
      if (ack_b) exp_b_q.push_back({last_b, data_b});
      next_cycle();
      cyc++;
    end
    checks++;
    if (src_a_q.size() + src_b_q.size() + exp_a_q.size() + exp_b_q.size() != 0) begin
      errors++; $display("FAIL rnd_timeout: got %0d beats outstanding expected 0",
                         src_a_q.size() + src_b_q.size() + exp_a_q.size() + exp_b_q.size());
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pause_en = 1'b0;
    ready_pct = 100;
    test_reset();
    test_single();
    test_tie_rr();
    test_forced_release();
    test_backpressure();
    test_withdraw_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
